// File: rtl/window_apply_pkg.sv
// Shared widths and the joined beat record for the window-apply stage.
package window_apply_pkg;

   localparam int SAMPLE_W_DEF  = 16;
   localparam int WIN_W_DEF     = 10;
   localparam int CNT_W_DEF     = 16;
   localparam int FRAME_LEN_DEF = 2 ** WIN_W_DEF;
   // Coefficient value that represents a gain of exactly 1.0
   localparam int UNITY_COEF    = 2 ** (WIN_W_DEF - 1);

   typedef struct packed {
      logic signed [SAMPLE_W_DEF-1:0] sample;
      logic        [WIN_W_DEF-1:0]    coef;
      logic                           last;
   } beat_t;

endpackage

// File: rtl/win_scale_mult.sv
// Registered signed sample x unsigned Q(WIN_W-1) coefficient, floor-scaled back to sample width.
// Latency: 1 clk from en to result.
// Backpressure: result holds its value whenever en is low.
module win_scale_mult #(
   parameter int SAMPLE_W = 16,
   parameter int WIN_W    = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [WIN_W-1:0]    coef,
   output logic [SAMPLE_W-1:0] result
);

   localparam int PROD_W = SAMPLE_W + WIN_W + 1;

   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] shifted;
   logic                     unused_hi;

   // Zero-extend the coefficient so it stays non-negative in the signed product
   assign prod      = PROD_W'($signed(sample)) * PROD_W'($signed({1'b0, coef}));
   assign shifted   = prod >>> (WIN_W - 1);
   // Coefficients within 0..unity never grow the magnitude, so the top bits are redundant
   assign unused_hi = ^shifted[PROD_W-1:SAMPLE_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result <= '0;
      end else if (en) begin
         result <= shifted[SAMPLE_W-1:0];
      end
   end

endmodule

// File: rtl/window_apply.sv
// Joins PCM samples with window coefficients, scales each sample and emits a framed stream; checks frame length.
// Latency: 2 clk from join to m_valid (S1 register, then registered multiply).
// Backpressure: m_ready stalls the pipe; bubbles collapse; inputs are only consumed together.
module window_apply
   import window_apply_pkg::*;
#(
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int WIN_W     = WIN_W_DEF,
   parameter int FRAME_LEN = 2 ** WIN_W,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] s_sample_data,
   input  logic                s_sample_valid,
   output logic                s_sample_ready,
   input  logic [WIN_W-1:0]    win_data,
   input  logic                win_valid,
   input  logic                win_last,
   output logic                win_ready,
   output logic [SAMPLE_W-1:0] m_data,
   output logic                m_valid,
   output logic                m_last,
   input  logic                m_ready,
   output logic                frame_err,
   output logic [CNT_W-1:0]    frame_count
);

   localparam int              BCNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(FRAME_LEN - 1);

   typedef struct packed {
      logic [SAMPLE_W-1:0] sample;
      logic [WIN_W-1:0]    coef;
      logic                last;
   } s1_beat_t;

   logic              s1_vld;
   s1_beat_t          s1_dat;
   logic              s2_adv;
   logic              adv;
   logic              join_vld;
   logic [BCNT_W-1:0] beat_cnt;

   assign s2_adv         = ~m_valid | m_ready;
   assign adv            = ~s1_vld | s2_adv;
   assign join_vld       = s_sample_valid & win_valid & adv;
   // Each side is only told ready when the other side is valid, so neither is consumed alone
   assign s_sample_ready = win_valid & adv;
   assign win_ready      = s_sample_valid & adv;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld <= 1'b0;
         s1_dat <= '0;
      end else if (adv) begin
         s1_vld <= join_vld;
         if (join_vld) begin
            s1_dat <= {s_sample_data, win_data, win_last};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (s2_adv) begin
         m_valid <= s1_vld;
         if (s1_vld) begin
            m_last <= s1_dat.last;
         end
      end
   end

   win_scale_mult #(
      .SAMPLE_W (SAMPLE_W),
      .WIN_W    (WIN_W)
   ) u_mult (
      .clk    (clk),
      .rst    (rst),
      .en     (s2_adv & s1_vld),
      .sample (s1_dat.sample),
      .coef   (s1_dat.coef),
      .result (m_data)
   );

   // Frame checker runs on the join, independent of downstream stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt    <= '0;
         frame_count <= '0;
         frame_err   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (join_vld) begin
            if (win_last) begin
               frame_err   <= (beat_cnt != LAST_IDX);
               beat_cnt    <= '0;
               frame_count <= frame_count + 1'b1;
            end else if (beat_cnt == LAST_IDX) begin
               frame_err <= 1'b1;
               beat_cnt  <= '0;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

endmodule
